// File: rtl/tm_feedback_ctrl.sv
// Training-feedback controller for a two-class Tsetlin machine.
// Accepts one sample (two vote sums + label), registers the argmax prediction,
// steps a 16-bit LFSR and issues one-cycle Type I / Type II feedback strobes.
// Also keeps saturating sample / error counters for accuracy readout.
module tm_feedback_ctrl #(
   parameter int          VOTE_W    = 2,
   parameter int          T         = 3,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_valid,
   output logic              sample_ready,
   input  logic              label,
   input  logic [VOTE_W-1:0] votes0,
   input  logic [VOTE_W-1:0] votes1,
   input  logic              train_en,
   output logic              prediction,
   output logic              fb_valid,
   output logic [1:0]        positive_feedback,
   output logic [1:0]        negative_feedback,
   output logic [15:0]       sample_count,
   output logic [15:0]       error_count
);

   // A zero seed would lock the LFSR, so it falls back to the default.
   localparam logic [15:0]       SEED_EFF = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
   // r*2T and (T+c)*256 both stay below 2^(VOTE_W+9); one spare bit avoids any truncation.
   localparam int                CMP_W    = VOTE_W + 10;
   localparam logic [VOTE_W-1:0] T_V      = VOTE_W'(T);

   typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DRAW, S_ISSUE} state_t;

   state_t              state_q, state_d;
   logic                label_q, train_q;
   logic [VOTE_W-1:0]   v0_q, v1_q;
   logic                pred_q, pred_d;
   logic [15:0]         scnt_q, ecnt_q;
   logic [15:0]         lfsr_q, lfsr_d;
   logic                fire_t_q, fire_o_q;
   logic                fire_t_d, fire_o_d;
   logic [VOTE_W-1:0]   c0, c1, c_y, c_o;
   logic                accept;

   function automatic logic [VOTE_W-1:0] clamp_vote(input logic [VOTE_W-1:0] v);
      return (v > T_V) ? T_V : v;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   // Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // Type I draw for the target class: fires with probability (T - c_y) / 2T
   function automatic logic draw_target(input logic [7:0] r, input logic [VOTE_W-1:0] c);
      logic [CMP_W-1:0] lhs;
      logic [CMP_W-1:0] rhs;
      lhs = CMP_W'(r) * CMP_W'(2 * T);
      rhs = (CMP_W'(T) - CMP_W'(c)) << 8;
      return lhs < rhs;
   endfunction

   // Type II draw for the other class: fires with probability (T + c_o) / 2T
   function automatic logic draw_other(input logic [7:0] r, input logic [VOTE_W-1:0] c);
      logic [CMP_W-1:0] lhs;
      logic [CMP_W-1:0] rhs;
      lhs = CMP_W'(r) * CMP_W'(2 * T);
      rhs = (CMP_W'(T) + CMP_W'(c)) << 8;
      return lhs < rhs;
   endfunction

   assign accept = sample_valid && (state_q == S_IDLE);

   // Clamped votes and the draw inputs derived from the latched sample.
   assign c0       = clamp_vote(v0_q);
   assign c1       = clamp_vote(v1_q);
   assign c_y      = label_q ? c1 : c0;
   assign c_o      = label_q ? c0 : c1;
   assign pred_d   = (c1 > c0);
   assign lfsr_d   = lfsr_step(lfsr_q);
   assign fire_t_d = train_q & draw_target(lfsr_d[7:0],  c_y);
   assign fire_o_d = train_q & draw_other(lfsr_d[15:8], c_o);

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic: fixed four-step walk per sample
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (sample_valid) state_d = S_EVAL;
         S_EVAL:  state_d = S_DRAW;
         S_DRAW:  state_d = S_ISSUE;
         S_ISSUE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: feedback buses are only driven during ISSUE
   always_comb begin
      sample_ready      = (state_q == S_IDLE);
      fb_valid          = (state_q == S_ISSUE);
      positive_feedback = 2'b00;
      negative_feedback = 2'b00;
      if (state_q == S_ISSUE) begin
         positive_feedback[label_q]  = fire_t_q;
         negative_feedback[~label_q] = fire_o_q;
      end
   end

   // Sample capture; pure data, only meaningful after an accept
   always_ff @(posedge clk) begin
      if (accept) begin
         label_q <= label;
         v0_q    <= votes0;
         v1_q    <= votes1;
         train_q <= train_en;
      end
   end

   // Prediction, counters, LFSR and registered draw decisions
   always_ff @(posedge clk) begin
      if (!rst) begin
         pred_q   <= 1'b0;
         scnt_q   <= 16'h0;
         ecnt_q   <= 16'h0;
         lfsr_q   <= SEED_EFF;
         fire_t_q <= 1'b0;
         fire_o_q <= 1'b0;
      end else begin
         if (state_q == S_EVAL) begin
            pred_q <= pred_d;
            scnt_q <= sat_inc(scnt_q);
            if (pred_d != label_q) ecnt_q <= sat_inc(ecnt_q);
         end
         if (state_q == S_DRAW) begin
            lfsr_q   <= lfsr_d;
            fire_t_q <= fire_t_d;
            fire_o_q <= fire_o_d;
         end
      end
   end

   assign prediction   = pred_q;
   assign sample_count = scnt_q;
   assign error_count  = ecnt_q;

endmodule

// File: tb/tb_tm_feedback_ctrl.sv
// Scoreboard bench for tm_feedback_ctrl: a driver issues samples and pushes the
// expected feedback record; a monitor pops and compares on every fb_valid.
module tb_tm_feedback_ctrl;
   localparam int VOTE_W = 2;
   localparam int T      = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              sample_valid = 1'b0;
   logic              sample_ready;
   logic              label = 1'b0;
   logic [VOTE_W-1:0] votes0 = '0;
   logic [VOTE_W-1:0] votes1 = '0;
   logic              train_en = 1'b0;
   logic              prediction;
   logic              fb_valid;
   logic [1:0]        positive_feedback;
   logic [1:0]        negative_feedback;
   logic [15:0]       sample_count;
   logic [15:0]       error_count;

   tm_feedback_ctrl #(.VOTE_W(VOTE_W), .T(T), .LFSR_SEED(16'hACE1)) dut (
      .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_ready(sample_ready),
      .label(label), .votes0(votes0), .votes1(votes1), .train_en(train_en),
      .prediction(prediction), .fb_valid(fb_valid),
      .positive_feedback(positive_feedback), .negative_feedback(negative_feedback),
      .sample_count(sample_count), .error_count(error_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0] cyc;
      logic        pred;
      logic [1:0]  pos;
      logic [1:0]  neg;
      logic [15:0] sc;
      logic [15:0] ec;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   bit   mon_en = 1'b0;
   bit   rate_phase = 1'b0;
   int   rate_t = 0;
   int   rate_o = 0;

   // Reference model state
   logic [15:0] m_lfsr = 16'hACE1;
   int          m_sc = 0;
   int          m_ec = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Shift register for the primitive polynomial with exponents 16,14,13,11
   function automatic logic [15:0] model_lfsr(input logic [15:0] s);
      int   exps[4];
      logic fb;
      exps = '{16, 14, 13, 11};
      fb = 1'b0;
      foreach (exps[i]) fb = fb ^ s[exps[i]-1];
      return {s[14:0], fb};
   endfunction

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Issue one sample, update the reference model and (optionally) expect its feedback.
   task automatic send(input logic lab, input int v0, input int v1, input logic te,
                       input bit expect_out, output int acc);
      int   w;
      int   c0, c1, cy, co, rt, ro;
      logic pred, ft, fo;
      exp_t e;
      @(negedge clk);
      label = lab; votes0 = VOTE_W'(v0); votes1 = VOTE_W'(v1); train_en = te;
      sample_valid = 1'b1;
      w = 0;
      while (!sample_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!sample_ready) begin
         checks++; failures++;
         $display("FAIL accept_timeout actual=ready_low required=ready_high");
         sample_valid = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc + 1;
      c0 = imin(v0, T);
      c1 = imin(v1, T);
      pred = (c1 > c0);
      if (m_sc < 65535) m_sc++;
      if (pred != lab && m_ec < 65535) m_ec++;
      m_lfsr = model_lfsr(m_lfsr);
      rt = int'(m_lfsr[7:0]);
      ro = int'(m_lfsr[15:8]);
      cy = lab ? c1 : c0;
      co = lab ? c0 : c1;
      ft = te && (rt * 2 * T < (T - cy) * 256);
      fo = te && (ro * 2 * T < (T + co) * 256);
      e.cyc  = 32'(acc);
      e.pred = pred;
      e.pos  = 2'b00;
      e.neg  = 2'b00;
      e.pos[lab]  = ft;
      e.neg[!lab] = fo;
      e.sc = 16'(m_sc);
      e.ec = 16'(m_ec);
      if (expect_out) q.push_back(e);
      @(posedge clk);
      #1 sample_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (q.size() > 0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (q.size() > 0) begin
         checks++; failures++;
         $display("FAIL drain actual=%0d_pending required=0", q.size());
         q.delete();
      end
   endtask

   // Monitor: every fb_valid pops one expected record; idle cycles must show zero feedback
   always @(negedge clk) begin
      if (mon_en) begin
         if (fb_valid) begin
            if (q.size() == 0) begin
               checks++; failures++;
               $display("FAIL fb_unexpected actual=fb_valid required=no_pulse");
            end else begin
               mon_e = q.pop_front();
               check("fb_cycle", 32'(cyc), mon_e.cyc + 32'd2);
               check("ready_low_in_issue", {31'b0, sample_ready}, 32'd0);
               check("positive_feedback", {30'b0, positive_feedback}, {30'b0, mon_e.pos});
               check("negative_feedback", {30'b0, negative_feedback}, {30'b0, mon_e.neg});
               check("prediction", {31'b0, prediction}, {31'b0, mon_e.pred});
               check("sample_count", {16'b0, sample_count}, {16'b0, mon_e.sc});
               check("error_count", {16'b0, error_count}, {16'b0, mon_e.ec});
               if (rate_phase) begin
                  rate_t += int'(positive_feedback[0]);
                  rate_o += int'(negative_feedback[1]);
               end
            end
         end else begin
            check("fb_zero_when_idle", {28'b0, positive_feedback, negative_feedback}, 32'd0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int acc, prev;
      // Reset for two cycles, then release
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", {31'b0, sample_ready}, 32'd1);
      check("rst_outputs", {26'b0, prediction, fb_valid, positive_feedback, negative_feedback}, 32'd0);
      check("rst_counts", {sample_count, error_count}, 32'd0);
      rst = 1'b1;
      mon_en = 1'b1;

      // Tie 3/3, label 1: predicts 0 (error), Type II to class 0 always, Type I never
      send(1'b1, 3, 3, 1'b1, 1'b1, acc);
      drain();
      check("tie_pred", {31'b0, prediction}, 32'd0);
      check("tie_err", {16'b0, error_count}, 32'd1);

      // Inference only: prediction 1, no error, buses stay 0
      send(1'b1, 0, 2, 1'b0, 1'b1, acc);
      drain();
      check("infer_pred_hold", {31'b0, prediction}, 32'd1);
      check("infer_err", {16'b0, error_count}, 32'd1);

      // Random samples, back-to-back accept spacing
      prev = -1;
      for (int i = 0; i < 200; i++) begin
         send(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'b1, acc);
         if (prev >= 0 && acc >= 0) check("b2b_gap", 32'(acc - prev), 32'd4);
         prev = acc;
      end
      drain();

      // Zero votes, label 0: both draws fire with probability one half
      rate_phase = 1'b1;
      for (int i = 0; i < 1000; i++) send(1'b0, 0, 0, 1'b1, 1'b1, acc);
      drain();
      rate_phase = 1'b0;
      check("rate_pos0_in_range", {31'b0, (rate_t >= 450 && rate_t <= 550)}, 32'd1);
      check("rate_neg1_in_range", {31'b0, (rate_o >= 450 && rate_o <= 550)}, 32'd1);

      // Reset while the sample sits in DRAW: no pulse, everything back to reset values
      send(1'b0, 3, 0, 1'b1, 1'b0, acc);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      m_lfsr = 16'hACE1; m_sc = 0; m_ec = 0;
      check("midrst_ready", {31'b0, sample_ready}, 32'd1);
      check("midrst_counts", {sample_count, error_count}, 32'd0);
      check("midrst_pred", {31'b0, prediction}, 32'd0);
      repeat (4) @(negedge clk);
      send(1'b1, 1, 2, 1'b1, 1'b1, acc);
      drain();

      // Saturation: preload both counters near full, then three mispredicts
      @(negedge clk);
      dut.scnt_q = 16'hFFFE;
      dut.ecnt_q = 16'hFFFE;
      m_sc = 65534; m_ec = 65534;
      for (int i = 0; i < 3; i++) send(1'b0, 0, 3, 1'b1, 1'b1, acc);
      drain();
      check("sat_sample", {16'b0, sample_count}, 32'h0000FFFF);
      check("sat_error", {16'b0, error_count}, 32'h0000FFFF);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/tm_feedback_ctrl.md
# tm_feedback_ctrl

Training-feedback controller for the two-class Tsetlin machine. It sits directly downstream of the class clause banks. Per sample it:
- consumes their 2-bit vote sums and the target label;
- registers the prediction;
- draws pseudo-random numbers;
- issues the one-cycle positive (Type I) and negative (Type II) feedback strobes that the class banks consume on their feedback inputs.

It also keeps saturating sample and error counters for on-board accuracy readout.

## Interface
Parameters:
- VOTE_W, 2, width of each class vote sum (unsigned clause-vote count)
- T, 3, feedback threshold; legal range 1..2^VOTE_W-1
- LFSR_SEED, 16'hACE1, LFSR reset value; if set to 0 the block uses 16'hACE1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-low
- sample_valid  in  1  votes/label/train_en valid
- sample_ready  out  1  block can accept a sample (high only in IDLE)
- label  in  1  target class index
- votes0  in  VOTE_W  vote sum of class 0
- votes1  in  VOTE_W  vote sum of class 1
- train_en  in  1  1 = generate feedback, 0 = inference only
- prediction  out  1  registered argmax of the last evaluated sample
- fb_valid  out  1  one-cycle strobe; the feedback outputs are valid this cycle
- positive_feedback  out  2  bit k = Type I feedback to class k
- negative_feedback  out  2  bit k = Type II feedback to class k
- sample_count  out  16  accepted samples, saturating at 16'hFFFF
- error_count  out  16  samples with prediction != label, saturating at 16'hFFFF

## Operation
- FSM states are IDLE → EVAL → DRAW → ISSUE → IDLE.
  - IDLE: sample_ready=1. On sample_valid&sample_ready, latch label, votes0, votes1 and train_en, then go to EVAL.
  - EVAL: clamp each vote to min(v,T). Set prediction = (c1 > c0) ? 1 : 0; a tie gives 0. Increment sample_count. Increment error_count if prediction != label. Go to DRAW.
  - DRAW: step the LFSR once (Fibonacci, x^16+x^14+x^13+x^11+1). Register the two draw decisions. Go to ISSUE.
  - ISSUE: assert fb_valid and the registered feedback bits. Go to IDLE.
- Draw rule, with y=label, o=~label, r_t=lfsr[7:0], r_o=lfsr[15:8] (post-step value):
  - fire_t = (r_t*2T < (T - c_y)*256)
  - fire_o = (r_o*2T < (T + c_o)*256)
  - Compare in 12-bit unsigned arithmetic; no truncation.
  - positive_feedback[y]=fire_t and negative_feedback[o]=fire_o. All other feedback bits are 0.
- Consequences of the rule:
  - c_y=T gives P(fire_t)=0.
  - c_o=T gives P(fire_o)=1.
  - c_y=0 or c_o=0 gives probability 1/2 (r<128).
- train_en=0: fb_valid still pulses in ISSUE, but both feedback buses are 0. The LFSR still steps.
- Counters saturate and never wrap.
- prediction holds its value until the next EVAL.

## Timing
- Reset, when rst=0 at a rising edge:
  - state=IDLE, sample_ready=1, prediction=0, fb_valid=0
  - positive_feedback=0, negative_feedback=0
  - sample_count=0, error_count=0, LFSR=seed
- Reset wins over any in-flight sample. A sample in EVAL, DRAW or ISSUE is dropped with no fb_valid.
- Cycle timeline for an accept on the edge at cycle t:
  - prediction and the counters update at the end of t+1.
  - fb_valid is high during t+3 only.
  - sample_ready is low during t+1..t+3 and high again at t+4.
  - Maximum throughput is one sample per 4 cycles.
- sample_valid while sample_ready=0 is ignored; there is no queuing. The input fields may change freely after the accept edge.
- Feedback outputs are 0 on every cycle where fb_valid=0.
- Back-to-back: sample_valid held high gives accepts at t, t+4, t+8, …

## Test plan
- Reset with rst=0 for 2 cycles, then release → all outputs 0, sample_ready=1, first LFSR step from 16'hACE1 matches the golden model.
- votes0=3, votes1=3, label=1, train_en=1 (T=3) → prediction=0, error_count=1, positive_feedback=00, negative_feedback=01, fb_valid high exactly at t+3.
- votes0=0, votes1=2, label=1, train_en=0 → prediction=1, error_count unchanged, fb_valid pulse with both buses 0.
- 1000 samples with votes0=0, votes1=0, label=0 → fire rates of positive_feedback[0] and negative_feedback[1] are each within 50%±5%; per-sample values match the golden LFSR model bit-exact.
- Assert rst=0 during DRAW → no fb_valid. After release, counters are 0 and the next sample completes normally.
- Preload to 16'hFFFE, then 3 mispredicted samples → error_count and sample_count stop at 16'hFFFF.
